// File: rtl/processor_datapath_if.sv
// Command/observation bundle between the control FSM (master) and the execution datapath (slave).
// Flags signal exists only when PROC_DATAPATH_FLAGS_EN is defined.
interface processor_datapath_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned DM_AW  = 8
) ();
    logic [DM_AW-1:0]  D_addr;
    logic              D_wr;
    logic              RF_s;
    logic              RF_W_en;
    logic [RF_AW-1:0]  RF_W_addr;
    logic [RF_AW-1:0]  RF_Ra_addr;
    logic [RF_AW-1:0]  RF_Rb_addr;
    logic [2:0]        Alu_s0;
    logic [DATA_W-1:0] Ra_data;
    logic [DATA_W-1:0] Rb_data;
    logic [DATA_W-1:0] Alu_out;
    logic [DATA_W-1:0] Rd_data;
`ifdef PROC_DATAPATH_FLAGS_EN
    logic [3:0]        Flags;
`endif

    modport master (
`ifdef PROC_DATAPATH_FLAGS_EN
        input  Flags,
`endif
        output D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
        input  Ra_data, Rb_data, Alu_out, Rd_data
    );

    modport slave (
`ifdef PROC_DATAPATH_FLAGS_EN
        output Flags,
`endif
        input  D_addr, D_wr, RF_s, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0,
        output Ra_data, Rb_data, Alu_out, Rd_data
    );
endinterface

// File: rtl/processor_datapath.sv
// Execution datapath: 16-entry RF, 8-function ALU, synchronous data memory, write-back mux.
// Optional registered {N,V,C,Z} flags under PROC_DATAPATH_FLAGS_EN.
module processor_datapath #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned DM_AW  = 8
) (
    input logic                 i_clk,
    input logic                 i_rst,
    processor_datapath_if.slave io_dp
);
    localparam int unsigned NumRegs  = 2 ** RF_AW;
    localparam int unsigned NumWords = 2 ** DM_AW;

    logic [DATA_W-1:0] r_rf  [NumRegs];
    logic [DATA_W-1:0] r_mem [NumWords];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] w_ra, w_rb, w_alu, w_wdata, w_opb, w_sum;
    logic              w_cin;

    assign w_ra = r_rf[io_dp.RF_Ra_addr];
    assign w_rb = r_rf[io_dp.RF_Rb_addr];

    // One adder serves A+B, A-B (A + ~B + 1) and A+1.
    always_comb begin
        w_opb = w_rb;
        w_cin = 1'b0;
        if (io_dp.Alu_s0 == 3'd2) begin
            w_opb = ~w_rb;
            w_cin = 1'b1;
        end else if (io_dp.Alu_s0 == 3'd7) begin
            w_opb = {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef PROC_DATAPATH_FLAGS_EN
    logic w_carry;
    assign {w_carry, w_sum} = {1'b0, w_ra} + {1'b0, w_opb} + {{DATA_W{1'b0}}, w_cin};
`else
    assign w_sum = w_ra + w_opb + {{(DATA_W-1){1'b0}}, w_cin};
`endif

    always_comb begin
        w_alu = '0;
        case (io_dp.Alu_s0)
            3'd0:    w_alu = '0;
            3'd1:    w_alu = w_sum;
            3'd2:    w_alu = w_sum;
            3'd3:    w_alu = w_ra;
            3'd4:    w_alu = w_ra ^ w_rb;
            3'd5:    w_alu = w_ra | w_rb;
            3'd6:    w_alu = w_ra & w_rb;
            default: w_alu = w_sum;
        endcase
    end

    assign w_wdata = io_dp.RF_s ? r_rd_data : w_alu;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                r_rf[i] <= '0;
            end
        end else if (io_dp.RF_W_en) begin
            r_rf[io_dp.RF_W_addr] <= w_wdata;
        end
    end

    // Read-first: the registered read sees the word from before any same-edge write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[io_dp.D_addr];
        end
    end

    // Memory contents survive reset; only the write is gated.
    always_ff @(posedge i_clk) begin
        if (!i_rst && io_dp.D_wr) begin
            r_mem[io_dp.D_addr] <= w_ra;
        end
    end

    assign io_dp.Ra_data = w_ra;
    assign io_dp.Rb_data = w_rb;
    assign io_dp.Alu_out = w_alu;
    assign io_dp.Rd_data = r_rd_data;

`ifdef PROC_DATAPATH_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_flags;
    logic       w_arith;

    assign w_arith = (io_dp.Alu_s0 == 3'd1) || (io_dp.Alu_s0 == 3'd2) || (io_dp.Alu_s0 == 3'd7);

    // {N, V, C, Z}; for subtraction C is the adder carry, i.e. NOT borrow.
    always_comb begin
        w_flags    = 4'b0000;
        w_flags[3] = w_alu[DATA_W-1];
        w_flags[0] = (w_alu == '0);
        if (w_arith) begin
            w_flags[2] = (w_ra[DATA_W-1] == w_opb[DATA_W-1]) &&
                         (w_sum[DATA_W-1] != w_ra[DATA_W-1]);
            w_flags[1] = w_carry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flags <= 4'b0000;
        end else if (io_dp.RF_W_en && !io_dp.RF_s) begin
            r_flags <= w_flags;
        end
    end

    assign io_dp.Flags = r_flags;
`endif
endmodule

// File: tb/tb_processor_datapath.sv
// Directed self-checking bench for processor_datapath; constants are built through the ALU,
// so no memory preload is needed. Flags checks compile only with PROC_DATAPATH_FLAGS_EN.
module tb_processor_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    processor_datapath_if #(.DATA_W(16), .RF_AW(4), .DM_AW(8)) dp ();

    processor_datapath #(.DATA_W(16), .RF_AW(4), .DM_AW(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_dp (dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dp.D_addr     = '0;
        dp.D_wr       = 1'b0;
        dp.RF_s       = 1'b0;
        dp.RF_W_en    = 1'b0;
        dp.RF_W_addr  = '0;
        dp.RF_Ra_addr = '0;
        dp.RF_Rb_addr = '0;
        dp.Alu_s0     = '0;
    endtask

    task automatic alu_wr(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] wa);
        dp.Alu_s0 = op; dp.RF_Ra_addr = ra; dp.RF_Rb_addr = rb; dp.RF_W_addr = wa;
        dp.RF_s = 1'b0; dp.RF_W_en = 1'b1;
        tick();
        dp.RF_W_en = 1'b0;
    endtask

    task automatic store(input logic [3:0] ra, input logic [7:0] addr);
        dp.RF_Ra_addr = ra; dp.D_addr = addr; dp.D_wr = 1'b1;
        tick();
        dp.D_wr = 1'b0;
    endtask

    // Shift-and-add from zero: double, then +1 where the bit is set.
    task automatic build_const(input logic [3:0] r, input logic [15:0] val);
        alu_wr(3'd0, r, r, r);
        for (int b = 15; b >= 0; b--) begin
            alu_wr(3'd1, r, r, r);
            if (val[b]) alu_wr(3'd7, r, r, r);
        end
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        dp.RF_Ra_addr = a;
        #1;
        v = dp.Ra_data;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        idle();
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            read_reg(i[3:0], v);
            n_cmp++;
            if (v !== 16'h0000) begin
                $display("FAIL reset_rf[%0d]: got %h want 0000", i, v); n_fail++;
            end
        end
        dp.RF_Rb_addr = 4'd9;
        #1;
        n_cmp++;
        if (dp.Rb_data !== 16'h0000) begin
            $display("FAIL reset_rb: got %h want 0000", dp.Rb_data); n_fail++;
        end
        n_cmp++;
        if (dp.Rd_data !== 16'h0000) begin
            $display("FAIL reset_rd: got %h want 0000", dp.Rd_data); n_fail++;
        end
`ifdef PROC_DATAPATH_FLAGS_EN
        n_cmp++;
        if (dp.Flags !== 4'b0000) begin
            $display("FAIL reset_flags: got %b want 0000", dp.Flags); n_fail++;
        end
`endif
        rst = 1'b0;
        idle();
        tick();
        // R1 = 1, mem[0x40] = 1, then reset lands with writes pending.
        alu_wr(3'd7, 4'd0, 4'd0, 4'd1);
        store(4'd1, 8'h40);
        dp.RF_Ra_addr = 4'd1; dp.D_addr = 8'h40; dp.D_wr = 1'b1;
        dp.Alu_s0 = 3'd7; dp.RF_W_addr = 4'd2; dp.RF_W_en = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dp.Ra_data !== 16'h0000) begin
            $display("FAIL reset_async_ra: got %h want 0000", dp.Ra_data); n_fail++;
        end
        tick();
        tick();
        n_cmp++;
        if (dp.Rd_data !== 16'h0000) begin
            $display("FAIL reset_hold_rd: got %h want 0000", dp.Rd_data); n_fail++;
        end
        rst = 1'b0;
        idle();
        read_reg(4'd2, v);
        n_cmp++;
        if (v !== 16'h0000) begin
            $display("FAIL reset_drop_rf: got %h want 0000", v); n_fail++;
        end
        dp.D_addr = 8'h40;
        tick();
        n_cmp++;
        if (dp.Rd_data !== 16'h0001) begin
            $display("FAIL reset_drop_mem: got %h want 0001", dp.Rd_data); n_fail++;
        end
    endtask

    task automatic test_load();
        logic [15:0] v;
        idle();
        build_const(4'd7, 16'h1234);
        store(4'd7, 8'h10);
        alu_wr(3'd0, 4'd0, 4'd0, 4'd1);
        dp.D_addr = 8'h10;
        tick();
        dp.RF_s = 1'b1; dp.RF_W_en = 1'b1; dp.RF_W_addr = 4'd1;
        tick();
        idle();
        read_reg(4'd1, v);
        n_cmp++;
        if (v !== 16'h1234) begin
            $display("FAIL load_r1: got %h want 1234", v); n_fail++;
        end
    endtask

    task automatic test_alu();
        logic [15:0] v;
        logic [15:0] exp_out [8];
        exp_out[0] = 16'h0000; exp_out[1] = 16'h0008; exp_out[2] = 16'h0002;
        exp_out[3] = 16'h0005; exp_out[4] = 16'h0006; exp_out[5] = 16'h0007;
        exp_out[6] = 16'h0001; exp_out[7] = 16'h0006;
        idle();
        build_const(4'd1, 16'h0005);
        build_const(4'd2, 16'h0003);
        alu_wr(3'd1, 4'd1, 4'd2, 4'd3);
        alu_wr(3'd2, 4'd1, 4'd2, 4'd4);
        alu_wr(3'd2, 4'd0, 4'd2, 4'd5);
        read_reg(4'd3, v);
        n_cmp++;
        if (v !== 16'h0008) begin $display("FAIL alu_add: got %h want 0008", v); n_fail++; end
        read_reg(4'd4, v);
        n_cmp++;
        if (v !== 16'h0002) begin $display("FAIL alu_sub: got %h want 0002", v); n_fail++; end
        read_reg(4'd5, v);
        n_cmp++;
        if (v !== 16'hFFFD) begin $display("FAIL alu_wrap: got %h want fffd", v); n_fail++; end
        dp.RF_Ra_addr = 4'd1; dp.RF_Rb_addr = 4'd2;
        for (int op = 0; op < 8; op++) begin
            dp.Alu_s0 = op[2:0];
            #1;
            n_cmp++;
            if (dp.Alu_out !== exp_out[op]) begin
                $display("FAIL alu_op%0d: got %h want %h", op, dp.Alu_out, exp_out[op]);
                n_fail++;
            end
        end
        // R1 <- R1+1 while reading R1 in the same cycle.
        dp.Alu_s0 = 3'd7; dp.RF_W_addr = 4'd1; dp.RF_W_en = 1'b1;
        #1;
        n_cmp++;
        if (dp.Ra_data !== 16'h0005) begin
            $display("FAIL rf_old_value: got %h want 0005", dp.Ra_data); n_fail++;
        end
        tick();
        dp.RF_W_en = 1'b0;
        n_cmp++;
        if (dp.Ra_data !== 16'h0006) begin
            $display("FAIL rf_new_value: got %h want 0006", dp.Ra_data); n_fail++;
        end
    endtask

    task automatic test_store();
        idle();
        store(4'd3, 8'h20);
        dp.D_addr = 8'h20;
        tick();
        n_cmp++;
        if (dp.Rd_data !== 16'h0008) begin
            $display("FAIL store_readback: got %h want 0008", dp.Rd_data); n_fail++;
        end
    endtask

    task automatic test_read_first();
        idle();
        build_const(4'd8, 16'hAAAA);
        build_const(4'd9, 16'h5555);
        store(4'd8, 8'h30);
        dp.D_addr = 8'h30; dp.RF_Ra_addr = 4'd9; dp.D_wr = 1'b1;
        tick();
        dp.D_wr = 1'b0;
        n_cmp++;
        if (dp.Rd_data !== 16'hAAAA) begin
            $display("FAIL read_first_old: got %h want aaaa", dp.Rd_data); n_fail++;
        end
        tick();
        n_cmp++;
        if (dp.Rd_data !== 16'h5555) begin
            $display("FAIL read_first_new: got %h want 5555", dp.Rd_data); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        // Rd_data is 0x5555 here; load-writeback and store to 0x30 share one edge.
        dp.D_addr = 8'h30; dp.D_wr = 1'b1; dp.RF_Ra_addr = 4'd3;
        dp.RF_s = 1'b1; dp.RF_W_en = 1'b1; dp.RF_W_addr = 4'd10;
        tick();
        idle();
        dp.D_addr = 8'h30;
        read_reg(4'd10, v);
        n_cmp++;
        if (v !== 16'h5555) begin $display("FAIL b2b_wb: got %h want 5555", v); n_fail++; end
        tick();
        n_cmp++;
        if (dp.Rd_data !== 16'h0008) begin
            $display("FAIL b2b_store: got %h want 0008", dp.Rd_data); n_fail++;
        end
    endtask

`ifdef PROC_DATAPATH_FLAGS_EN
    task automatic test_flags();
        logic [15:0] v;
        idle();
        build_const(4'd5, 16'hFFFF);
        alu_wr(3'd7, 4'd5, 4'd5, 4'd6);
        read_reg(4'd6, v);
        n_cmp++;
        if (v !== 16'h0000) begin $display("FAIL flags_r6: got %h want 0000", v); n_fail++; end
        n_cmp++;
        if (dp.Flags !== 4'b0011) begin
            $display("FAIL flags_zc: got %b want 0011", dp.Flags); n_fail++;
        end
        // Load write-back must leave the flags alone.
        dp.RF_s = 1'b1; dp.RF_W_en = 1'b1; dp.RF_W_addr = 4'd13;
        tick();
        idle();
        n_cmp++;
        if (dp.Flags !== 4'b0011) begin
            $display("FAIL flags_hold: got %b want 0011", dp.Flags); n_fail++;
        end
        build_const(4'd11, 16'h7FFF);
        alu_wr(3'd7, 4'd11, 4'd11, 4'd12);
        n_cmp++;
        if (dp.Flags !== 4'b1100) begin
            $display("FAIL flags_nv: got %b want 1100", dp.Flags); n_fail++;
        end
        build_const(4'd1, 16'h0005);
        build_const(4'd2, 16'h0003);
        alu_wr(3'd2, 4'd1, 4'd2, 4'd14);
        n_cmp++;
        if (dp.Flags !== 4'b0010) begin
            $display("FAIL flags_sub: got %b want 0010", dp.Flags); n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_alu();
        test_store();
        test_read_first();
        test_back_to_back();
`ifdef PROC_DATAPATH_FLAGS_EN
        test_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
